rs_param: RTL

- Parametrised reservation station for the out-of-order core, sitting between the issue stage and the ALU.
- Holds DEPTH pending ALU ops and snoops CDB_N result broadcast channels (ALU, LSB, future units) to resolve operand tags.
- Dispatches the oldest ready entry to the ALU through a valid/ready handshake with backpressure.
- New versus the previous generation: configurable depth and CDB count, oldest-first select, same-cycle wakeup on issue, ALU stall support, occupancy count.

---
 rtl/rs_param.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rs_param.sv
// Reservation station for the ALU: DEPTH entries, CDB_N-channel tag wakeup,
// oldest-ready select via an age matrix, and a valid/ready output register.
module rs_param #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned CDB_N = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    issue,
    input  logic [6:0]              issue_opcode,
    input  logic [2:0]              issue_funct3,
    input  logic                    issue_funct7,
    input  logic [XLEN-1:0]         issue_imm,
    input  logic [XLEN-1:0]         issue_pc,
    input  logic [ROB_W-1:0]        issue_rob_pos,
    input  logic                    issue_rs1_pend,
    input  logic [ROB_W-1:0]        issue_rs1_tag,
    input  logic [XLEN-1:0]         issue_rs1_val,
    input  logic                    issue_rs2_pend,
    input  logic [ROB_W-1:0]        issue_rs2_tag,
    input  logic [XLEN-1:0]         issue_rs2_val,
    output logic                    rs_nxt_full,
    output logic [$clog2(DEPTH):0]  rs_count,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]  cdb_tag,
    input  logic [CDB_N*XLEN-1:0]   cdb_val,
    output logic                    alu_en,
    input  logic                    alu_ready,
    output logic [6:0]              alu_opcode,
    output logic [2:0]              alu_funct3,
    output logic                    alu_funct7,
    output logic [XLEN-1:0]         alu_imm,
    output logic [XLEN-1:0]         alu_pc,
    output logic [ROB_W-1:0]        alu_rob_pos,
    output logic [XLEN-1:0]         alu_val1,
    output logic [XLEN-1:0]         alu_val2
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] rob_pos;
        logic             p1;
        logic [ROB_W-1:0] t1;
        logic [XLEN-1:0]  v1;
        logic             p2;
        logic [ROB_W-1:0] t2;
        logic [XLEN-1:0]  v2;
    } entry_t;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
        logic [ROB_W-1:0] rob_pos;
        logic [XLEN-1:0]  val1;
        logic [XLEN-1:0]  val2;
    } out_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // older_q[j][i] set means entry j was issued before entry i.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    out_t             alu_q, alu_d;
    logic             alu_en_q, alu_en_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [XLEN:0]    wake1 [DEPTH];
    logic [XLEN:0]    wake2 [DEPTH];
    logic [XLEN:0]    iss1, iss2;
    logic [DEPTH-1:0] ready, oldest;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             any_ready, has_free, load, issue_ok;

    // {hit, value}; descending scan so the lowest matching channel wins.
    function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int k = int'(CDB_N) - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == tag) begin
                r = {1'b1, cdb_val[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    always_comb begin
        iss1 = cdb_lookup(issue_rs1_tag);
        iss2 = cdb_lookup(issue_rs2_tag);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wake1[i] = cdb_lookup(ent_q[i].t1);
            wake2[i] = cdb_lookup(ent_q[i].t2);
        end
    end

    always_comb begin
        ready     = '0;
        oldest    = '0;
        sel_idx   = '0;
        any_ready = 1'b0;
        free_idx  = '0;
        has_free  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] && !ent_q[i].p1 && !ent_q[i].p2;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) oldest[i] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (oldest[i]) begin
                sel_idx   = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
                has_free = 1'b1;
            end
        end
    end

    assign load     = rdy && !rollback && any_ready && (!alu_en_q || alu_ready);
    assign issue_ok = rdy && !rollback && issue && has_free;

    always_comb begin
        valid_d  = valid_q;
        ent_d    = ent_q;
        older_d  = older_q;
        alu_d    = alu_q;
        alu_en_d = alu_en_q;
        count_d  = count_q;
        if (rdy) begin
            if (rollback) begin
                valid_d  = '0;
                alu_en_d = 1'b0;
                count_d  = '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && ent_q[i].p1 && wake1[i][XLEN]) begin
                        ent_d[i].p1 = 1'b0;
                        ent_d[i].v1 = wake1[i][XLEN-1:0];
                    end
                    if (valid_q[i] && ent_q[i].p2 && wake2[i][XLEN]) begin
                        ent_d[i].p2 = 1'b0;
                        ent_d[i].v2 = wake2[i][XLEN-1:0];
                    end
                end
                if (load) begin
                    valid_d[sel_idx] = 1'b0;
                    alu_en_d         = 1'b1;
                    alu_d.opcode     = ent_q[sel_idx].opcode;
                    alu_d.funct3     = ent_q[sel_idx].funct3;
                    alu_d.funct7     = ent_q[sel_idx].funct7;
                    alu_d.imm        = ent_q[sel_idx].imm;
                    alu_d.pc         = ent_q[sel_idx].pc;
                    alu_d.rob_pos    = ent_q[sel_idx].rob_pos;
                    alu_d.val1       = ent_q[sel_idx].v1;
                    alu_d.val2       = ent_q[sel_idx].v2;
                end else if (alu_en_q && alu_ready) begin
                    alu_en_d = 1'b0;
                end
                // free_idx comes from valid_q, so a slot freed by this dispatch is not reused.
                if (issue_ok) begin
                    valid_d[free_idx]         = 1'b1;
                    ent_d[free_idx].opcode    = issue_opcode;
                    ent_d[free_idx].funct3    = issue_funct3;
                    ent_d[free_idx].funct7    = issue_funct7;
                    ent_d[free_idx].imm       = issue_imm;
                    ent_d[free_idx].pc        = issue_pc;
                    ent_d[free_idx].rob_pos   = issue_rob_pos;
                    ent_d[free_idx].p1        = issue_rs1_pend && !iss1[XLEN];
                    ent_d[free_idx].t1        = issue_rs1_tag;
                    ent_d[free_idx].v1        = (issue_rs1_pend && iss1[XLEN]) ?
                                                iss1[XLEN-1:0] : issue_rs1_val;
                    ent_d[free_idx].p2        = issue_rs2_pend && !iss2[XLEN];
                    ent_d[free_idx].t2        = issue_rs2_tag;
                    ent_d[free_idx].v2        = (issue_rs2_pend && iss2[XLEN]) ?
                                                iss2[XLEN-1:0] : issue_rs2_val;
                    older_d[free_idx]         = '0;
                    for (int unsigned j = 0; j < DEPTH; j++) begin
                        if (IDX_W'(j) != free_idx) older_d[j][free_idx] = 1'b1;
                    end
                end
                count_d = count_q + CNT_W'(issue_ok) - CNT_W'(load);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            alu_q    <= '0;
            alu_en_q <= 1'b0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            alu_q    <= alu_d;
            alu_en_q <= alu_en_d;
            count_q  <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i]   <= ent_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

    // Same-cycle dispatch is deliberately not credited here.
    assign rs_nxt_full = ({1'b0, count_q} + (CNT_W+1)'(issue)) >= (CNT_W+1)'(DEPTH);
    assign rs_count    = count_q;
    assign alu_en      = alu_en_q;
    assign alu_opcode  = alu_q.opcode;
    assign alu_funct3  = alu_q.funct3;
    assign alu_funct7  = alu_q.funct7;
    assign alu_imm     = alu_q.imm;
    assign alu_pc      = alu_q.pc;
    assign alu_rob_pos = alu_q.rob_pos;
    assign alu_val1    = alu_q.val1;
    assign alu_val2    = alu_q.val2;

endmodule
